mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 123 ++++++++++++
 tb/tb_mem_responder.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Single-port word memory behind a req/ready handshake with a fixed, parameterised
// wait time between acceptance and the one-cycle completion pulse.
module mem_responder #(
    parameter int DEPTH = 64,
    parameter int WAIT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        ready,
    output logic        err
);

    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit              WAIT_ZERO = (WAIT == 0);
    localparam logic [3:0]      WAIT_LAST = (WAIT > 0) ? 4'(WAIT - 1) : 4'd0;
    localparam logic [29:0]     IDX_LIMIT = 30'(DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_RESP
    } state_t;

    state_t      state_reg;
    logic [3:0]  cnt_reg;
    logic [31:0] adr_reg;
    logic [31:0] wdata_reg;
    logic        we_reg;
    logic        rej_reg;

    logic [31:0] mem [DEPTH];

    // With a zero wait time the memory operation happens on the accepting edge,
    // before anything is latched, so the live request fields are used then.
    logic          from_idle;
    logic [31:0]   cur_adr;
    logic [31:0]   cur_wdata;
    logic          cur_we;
    logic          cur_rej;
    logic [AW-1:0] cur_idx;
    logic          enter_resp;
    logic          mem_wr;

    always_comb begin
        from_idle = (state_reg == ST_IDLE);
        cur_adr   = from_idle ? adr       : adr_reg;
        cur_wdata = from_idle ? writedata : wdata_reg;
        cur_we    = from_idle ? we        : we_reg;
        cur_rej   = (cur_adr[1:0] != 2'b00) || (cur_adr[31:2] >= IDX_LIMIT);
        cur_idx   = cur_adr[AW+1:2];
        if (WAIT_ZERO) begin
            enter_resp = from_idle && req;
        end else begin
            enter_resp = (state_reg == ST_WAIT) && (cnt_reg == WAIT_LAST);
        end
        // Gated by reset so a write cannot slip in while the FSM is held in reset.
        mem_wr = reset && enter_resp && cur_we && !cur_rej;
    end

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            mem[cur_idx] <= cur_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 4'd0;
            adr_reg   <= 32'd0;
            wdata_reg <= 32'd0;
            we_reg    <= 1'b0;
            rej_reg   <= 1'b0;
            ready     <= 1'b0;
            err       <= 1'b0;
            readdata  <= 32'd0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (req) begin
                        adr_reg   <= adr;
                        wdata_reg <= writedata;
                        we_reg    <= we;
                        cnt_reg   <= 4'd0;
                        state_reg <= WAIT_ZERO ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt_reg == WAIT_LAST) begin
                        cnt_reg   <= 4'd0;
                        state_reg <= ST_RESP;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                ST_RESP: begin
                    ready     <= 1'b1;
                    err       <= rej_reg;
                    cnt_reg   <= 4'd0;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase

            if (enter_resp) begin
                rej_reg <= cur_rej;
                if (!cur_we && !cur_rej) begin
                    readdata <= mem[cur_idx];
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Randomised bench for mem_responder: a WAIT=2 instance checked against an array model,
// plus a WAIT=0 instance for the single-cycle latency case.
module tb_mem_responder;

    localparam int W = 2;
    localparam int D = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, req, we;
    logic [31:0] adr, writedata, readdata;
    logic        ready, err;

    logic        reset0, req0, we0;
    logic [31:0] adr0, writedata0, readdata0;
    logic        ready0, err0;

    mem_responder #(.DEPTH(D), .WAIT(W)) dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .adr(adr),
        .writedata(writedata), .readdata(readdata), .ready(ready), .err(err)
    );

    mem_responder #(.DEPTH(D), .WAIT(0)) dut0 (
        .clk(clk), .reset(reset0), .req(req0), .we(we0), .adr(adr0),
        .writedata(writedata0), .readdata(readdata0), .ready(ready0), .err(err0)
    );

    int n_checks = 0;
    int n_errors = 0;
    int stray_err = 0;

    logic [31:0] model_mem [D];
    logic [31:0] model_rd;

    // Issues one access and waits (bounded) for its ready pulse; lat counts edges after acceptance.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          output int lat, output logic [31:0] rd, output logic e);
        lat = -1;
        rd  = 'x;
        e   = 1'bx;
        @(negedge clk);
        req = 1'b1; we = w; adr = a; writedata = d;
        @(posedge clk); #1;
        req = 1'b0;
        we = 1'($urandom_range(0, 1));
        adr = $urandom;
        writedata = $urandom;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (!ready && err) stray_err++;
            if (ready) begin
                lat = i; rd = readdata; e = err;
                break;
            end
        end
        $display("txn we=%0d adr=%08h wdata=%08h lat=%0d err=%0d rdata=%08h", w, a, d, lat, e, rd);
    endtask

    task automatic test_reset();
        reset = 1'b0; req = 1'b0; we = 1'b0; adr = 32'd0; writedata = 32'd0;
        reset0 = 1'b0; req0 = 1'b0; we0 = 1'b0; adr0 = 32'd0; writedata0 = 32'd0;
        model_rd = 32'd0;
        #2;
        n_checks++;
        if (ready !== 1'b0) begin n_errors++; $display("FAIL reset_ready: got %b want 0", ready); end
        n_checks++;
        if (err !== 1'b0) begin n_errors++; $display("FAIL reset_err: got %b want 0", err); end
        n_checks++;
        if (readdata !== 32'd0) begin n_errors++; $display("FAIL reset_readdata: got %08h want 00000000", readdata); end
        n_checks++;
        if (ready0 !== 1'b0 || readdata0 !== 32'd0) begin
            n_errors++; $display("FAIL reset_dut0: got ready=%b rdata=%08h want 0/00000000", ready0, readdata0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b1;
        reset0 = 1'b1;
    endtask

    task automatic test_fill();
        int lat; logic [31:0] rd, d; logic e;
        for (int i = 0; i < D; i++) begin
            d = $urandom;
            access(1'b1, 32'(i * 4), d, lat, rd, e);
            model_mem[i] = d;
            n_checks++;
            if (lat !== W + 1 || e !== 1'b0 || rd !== model_rd) begin
                n_errors++;
                $display("FAIL fill_%0d: got lat=%0d err=%b rdata=%08h want lat=%0d err=0 rdata=%08h",
                         i, lat, e, rd, W + 1, model_rd);
            end
        end
    endtask

    task automatic test_basic();
        int lat; logic [31:0] rd; logic e;
        access(1'b1, 32'h8, 32'hDEADBEEF, lat, rd, e);
        model_mem[2] = 32'hDEADBEEF;
        n_checks++;
        if (lat !== W + 1) begin n_errors++; $display("FAIL basic_wr_lat: got %0d want %0d", lat, W + 1); end
        n_checks++;
        if (e !== 1'b0) begin n_errors++; $display("FAIL basic_wr_err: got %b want 0", e); end
        n_checks++;
        if (rd !== model_rd) begin n_errors++; $display("FAIL basic_wr_rdata: got %08h want %08h", rd, model_rd); end
        access(1'b0, 32'h8, 32'h0, lat, rd, e);
        model_rd = 32'hDEADBEEF;
        n_checks++;
        if (lat !== W + 1) begin n_errors++; $display("FAIL basic_rd_lat: got %0d want %0d", lat, W + 1); end
        n_checks++;
        if (e !== 1'b0) begin n_errors++; $display("FAIL basic_rd_err: got %b want 0", e); end
        n_checks++;
        if (rd !== 32'hDEADBEEF) begin n_errors++; $display("FAIL basic_rd_data: got %08h want deadbeef", rd); end
    endtask

    task automatic test_errors();
        int lat; logic [31:0] rd; logic e;
        logic [31:0] adrs [7];
        logic        wes  [7];
        adrs = '{32'h4, 32'h6, 32'h100, 32'h5, 32'h100, 32'h80000000, 32'h4};
        wes  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int k = 0; k < 7; k++) begin
            logic rej;
            rej = (adrs[k][1:0] != 2'b00) || (adrs[k][31:2] >= 30'(D));
            access(wes[k], adrs[k], ~model_mem[1], lat, rd, e);
            if (!rej && !wes[k]) model_rd = model_mem[adrs[k][7:2]];
            n_checks++;
            if (lat !== W + 1 || e !== rej || rd !== model_rd) begin
                n_errors++;
                $display("FAIL errors_%0d adr=%08h: got lat=%0d err=%b rdata=%08h want lat=%0d err=%b rdata=%08h",
                         k, adrs[k], lat, e, rd, W + 1, rej, model_rd);
            end
        end
    endtask

    task automatic test_random();
        int lat; logic [31:0] rd, a, d; logic e, w, rej;
        int idx, low;
        for (int k = 0; k < 40; k++) begin
            idx = $urandom_range(0, D + 7);
            low = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
            a = 32'(idx * 4 + low);
            d = $urandom;
            w = 1'($urandom_range(0, 1));
            rej = (low != 0) || (idx >= D);
            access(w, a, d, lat, rd, e);
            if (!rej && w) model_mem[idx] = d;
            if (!rej && !w) model_rd = model_mem[idx];
            n_checks++;
            if (lat !== W + 1 || e !== rej || rd !== model_rd) begin
                n_errors++;
                $display("FAIL random_%0d adr=%08h we=%b: got lat=%0d err=%b rdata=%08h want lat=%0d err=%b rdata=%08h",
                         k, a, w, lat, e, rd, W + 1, rej, model_rd);
            end
        end
    endtask

    task automatic test_addr_change();
        int lat; logic [31:0] rd; logic e;
        lat = -1; rd = 'x; e = 1'bx;
        @(negedge clk);
        req = 1'b1; we = 1'b0; adr = 32'h10; writedata = 32'h0;
        @(posedge clk); #1;
        req = 1'b0; adr = 32'h14; we = 1'b1; writedata = $urandom;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk); #1;
            if (ready) begin lat = i; rd = readdata; e = err; break; end
        end
        $display("txn we=0 adr=00000010 (adr moved to 00000014) lat=%0d err=%0d rdata=%08h", lat, e, rd);
        model_rd = model_mem[4];
        n_checks++;
        if (lat !== W + 1 || e !== 1'b0 || rd !== model_mem[4]) begin
            n_errors++;
            $display("FAIL addr_change: got lat=%0d err=%b rdata=%08h want lat=%0d err=0 rdata=%08h",
                     lat, e, rd, W + 1, model_mem[4]);
        end
        access(1'b0, 32'h14, 32'h0, lat, rd, e);
        model_rd = model_mem[5];
        n_checks++;
        if (rd !== model_mem[5] || e !== 1'b0) begin
            n_errors++; $display("FAIL addr_change_mem5: got %08h err=%b want %08h err=0", rd, e, model_mem[5]);
        end
    endtask

    task automatic test_back_to_back();
        int pulses = 0, last = 0, sel = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; adr = 32'h0; writedata = 32'h0;
        for (int cyc = 1; cyc <= 80; cyc++) begin
            @(posedge clk); #1;
            if (ready) begin
                model_rd = model_mem[sel];
                $display("txn b2b pulse=%0d cyc=%0d err=%0d rdata=%08h", pulses, cyc, err, readdata);
                n_checks++;
                if (err !== 1'b0 || readdata !== model_mem[sel]) begin
                    n_errors++;
                    $display("FAIL b2b_data_%0d: got err=%b rdata=%08h want err=0 rdata=%08h",
                             pulses, err, readdata, model_mem[sel]);
                end
                n_checks++;
                if (cyc - last !== W + 2) begin
                    n_errors++; $display("FAIL b2b_spacing_%0d: got %0d want %0d", pulses, cyc - last, W + 2);
                end
                last = cyc;
                pulses++;
                sel = 1 - sel;
                adr = (sel == 1) ? 32'h4 : 32'h0;
                if (pulses == 6) begin
                    req = 1'b0;
                    break;
                end
            end
        end
        n_checks++;
        if (pulses !== 6) begin n_errors++; $display("FAIL b2b_count: got %0d want 6", pulses); end
    endtask

    task automatic test_reset_abort();
        int lat; logic [31:0] rd; logic e;
        access(1'b1, 32'hC, 32'h22222222, lat, rd, e);
        model_mem[3] = 32'h22222222;
        @(negedge clk);
        req = 1'b1; we = 1'b1; adr = 32'hC; writedata = 32'h11111111;
        @(posedge clk); #1;
        req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        model_rd = 32'd0;
        n_checks++;
        if (ready !== 1'b0 || err !== 1'b0 || readdata !== 32'd0) begin
            n_errors++;
            $display("FAIL abort_outputs: got ready=%b err=%b rdata=%08h want 0/0/00000000", ready, err, readdata);
        end
        @(negedge clk);
        reset = 1'b1;
        access(1'b0, 32'hC, 32'h0, lat, rd, e);
        model_rd = model_mem[3];
        n_checks++;
        if (lat !== W + 1 || e !== 1'b0 || rd !== 32'h22222222) begin
            n_errors++;
            $display("FAIL abort_readback: got lat=%0d err=%b rdata=%08h want lat=%0d err=0 rdata=22222222",
                     lat, e, rd, W + 1);
        end
        // Reset landing on a rejected response must drop ready and err immediately.
        access(1'b0, 32'h6, 32'h0, lat, rd, e);
        n_checks++;
        if (e !== 1'b1) begin n_errors++; $display("FAIL abort_rej_err: got %b want 1", e); end
        reset = 1'b0;
        #1;
        model_rd = 32'd0;
        n_checks++;
        if (ready !== 1'b0 || err !== 1'b0) begin
            n_errors++; $display("FAIL abort_pulse: got ready=%b err=%b want 0/0", ready, err);
        end
        @(negedge clk);
        reset = 1'b1;
        access(1'b0, 32'h0, 32'h0, lat, rd, e);
        model_rd = model_mem[0];
        n_checks++;
        if (lat !== W + 1 || rd !== model_mem[0]) begin
            n_errors++;
            $display("FAIL abort_recover: got lat=%0d rdata=%08h want lat=%0d rdata=%08h", lat, rd, W + 1, model_mem[0]);
        end
    endtask

    task automatic test_wait0();
        logic [31:0] val;
        logic [31:0] exp_rd;
        val = $urandom;
        exp_rd = 32'd0;
        for (int k = 0; k < 3; k++) begin
            int lat; logic [31:0] rd; logic e, exp_e;
            lat = -1; rd = 'x; e = 1'bx;
            exp_e = (k == 2);
            @(negedge clk);
            req0 = 1'b1; we0 = (k == 0); adr0 = (k == 2) ? 32'h2 : 32'h0; writedata0 = val;
            @(posedge clk); #1;
            req0 = 1'b0; adr0 = $urandom; we0 = 1'($urandom_range(0, 1)); writedata0 = $urandom;
            for (int i = 1; i <= 20; i++) begin
                @(posedge clk); #1;
                if (ready0) begin lat = i; rd = readdata0; e = err0; break; end
            end
            if (k == 1) exp_rd = val;
            $display("txn wait0 k=%0d lat=%0d err=%0d rdata=%08h", k, lat, e, rd);
            n_checks++;
            if (lat !== 1 || e !== exp_e || rd !== exp_rd) begin
                n_errors++;
                $display("FAIL wait0_%0d: got lat=%0d err=%b rdata=%08h want lat=1 err=%b rdata=%08h",
                         k, lat, e, rd, exp_e, exp_rd);
            end
        end
    endtask

    task automatic test_err_qualify();
        n_checks++;
        if (stray_err !== 0) begin
            n_errors++; $display("FAIL err_without_ready: got %0d cycles want 0", stray_err);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_errors();
        test_random();
        test_addr_change();
        test_back_to_back();
        test_reset_abort();
        test_wait0();
        test_err_qualify();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
